// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU.
// ALU_MUL_EN adds the BUSY state used by the iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010,
    ALU_NOP  = 4'b1111
  } alu_ctrl_t;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: ALU_Op/func3/func7 to alu_ctrl_t.
// ALU_MUL_EN enables the MUL decode; otherwise M-ext is NOP.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALU_Op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_ctrl_t  ctrl
);

  logic is_r;
  assign is_r = (ALU_Op == ALU_OP_RTYPE);

  // Decode; I-type func7 is immediate so only R-type sees M-ext.
  always_comb begin
    ctrl = ALU_NOP;
    unique case (1'b1)
      (ALU_Op == ALU_OP_MEM):    ctrl = ALU_ADD;
      (ALU_Op == ALU_OP_BRANCH): ctrl = ALU_SUB;
      (is_r && func7 == F7_MULDIV): begin
`ifdef ALU_MUL_EN
        ctrl = (func3 == 3'b000) ? ALU_MUL : ALU_NOP;
`else
        ctrl = ALU_NOP;
`endif
      end
      default: begin
        unique case (func3)
          3'b000: ctrl = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: ctrl = ALU_SLL;
          3'b010: ctrl = ALU_SLT;
          3'b011: ctrl = ALU_SLTU;
          3'b100: ctrl = ALU_XOR;
          3'b101: ctrl = func7[5] ? ALU_SRA : ALU_SRL;
          3'b110: ctrl = ALU_OR;
          3'b111: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU, registered result.
// ALU_MUL_EN adds a one-bit-per-cycle shift-add multiplier.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALU_Op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  alu_ctrl_t       ctrl;
  alu_state_t      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            accept;

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
  logic [SHW-1:0]  step_q, step_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mul_sum;
`endif

  alu_op_decode u_dec (
    .ALU_Op (ALU_Op),
    .func3  (func3),
    .func7  (func7),
    .ctrl   (ctrl)
  );

  assign shamt     = src_b[SHW-1:0];
  assign in_ready  = (state_q == S_IDLE) |
                     ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  // Single-cycle operations on the live operands.
  always_comb begin
    alu_res = '0;
    unique case (ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                           ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Next state, result latch and multiplier stepping.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    step_d   = step_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_MUL_EN
          if (ctrl == ALU_MUL) begin
            state_d  = S_BUSY;
            step_d   = '0;
            acc_d    = '0;
            mcand_d  = src_a;
            mplier_d = src_b;
          end else begin
`endif
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
`ifdef ALU_MUL_EN
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
        if (step_q == LAST) begin
          state_d  = S_DONE;
          result_d = mul_sum;
          zero_d   = (mul_sum == '0);
          step_d   = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_MUL_EN
      step_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      step_q   <= step_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed checks of the execute-stage ALU.
// Define ALU_MUL_EN to also exercise the multiplier.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALU_Op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int ncmp = 0;
  int nfail = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_Op    (ALU_Op),
    .func3     (func3),
    .func7     (func7),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b);
    ALU_Op = op; func3 = f3; func7 = f7; src_a = a; src_b = b;
  endtask

  task automatic run(input string tag, input logic [1:0] op,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ez);
    drive(op, f3, f7, a, b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    drive(2'b10, 3'b000, 7'h00, 32'hDEAD_BEEF, 32'h1234_5678);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".zero"}, {31'b0, zero}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(2'b00, 3'b000, 7'h00, 32'd0, 32'd0);
    #2;
    chk_reset("reset");
    tick();
    rst = 1'b0;

    run("sub", 2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run("addi", 2'b11, 3'b000, 7'h20, 32'd5, 32'd7, 32'd12, 1'b0);
    run("srai", 2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd4,
        32'hF800_0000, 1'b0);
    run("srl", 2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4,
        32'h0800_0000, 1'b0);
    run("slt", 2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run("sltu", 2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run("sub_eq", 2'b10, 3'b000, 7'h20, 32'd9, 32'd9, 32'd0, 1'b1);
    run("sll_mask", 2'b10, 3'b001, 7'h00, 32'd1, 32'h21, 32'd2, 1'b0);
    run("and", 2'b10, 3'b111, 7'h00, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    run("or", 2'b10, 3'b110, 7'h00, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
    run("xor", 2'b10, 3'b100, 7'h00, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);
    run("ld_add_wrap", 2'b00, 3'b111, 7'h20, 32'hFFFF_FFFF, 32'd1,
        32'd0, 1'b1);
    run("br_sub", 2'b01, 3'b110, 7'h00, 32'd0, 32'd1,
        32'hFFFF_FFFF, 1'b0);
    run("mext_nop", 2'b10, 3'b100, 7'h01, 32'd3, 32'd4, 32'd0, 1'b1);

`ifdef ALU_MUL_EN
    drive(2'b10, 3'b000, 7'h01, 32'h0001_0001, 32'h0001_0001);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cnt = 1;
    while (!out_valid && cnt < 100) begin
      chk("mul.in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      cnt++;
    end
    chk("mul.latency", cnt, 32'd33);
    chk("mul.result", result, 32'h0002_0001);
    chk("mul.zero", {31'b0, zero}, 32'd0);
`else
    run("mul_off_nop", 2'b10, 3'b000, 7'h01, 32'd3, 32'd4, 32'd0, 1'b1);
`endif

    out_ready = 1'b1;
    tick();
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    drive(2'b10, 3'b000, 7'h00, 32'd1, 32'd2);
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    drive(2'b10, 3'b100, 7'h00, 32'hAA, 32'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("hold.in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold.out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold.result", result, 32'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("release.result", result, 32'hA5);
    chk("release.out_valid", {31'b0, out_valid}, 32'd1);

    for (int i = 1; i <= 3; i++) begin
      drive(2'b00, 3'b000, 7'h00, i, 32'd10);
      tick();
      chk("b2b.out_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b.result", result, 32'(i + 10));
    end
    in_valid = 1'b0;

    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_reset("rst_done");
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef ALU_MUL_EN
    drive(2'b10, 3'b000, 7'h01, 32'h1234_5678, 32'h0000_FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_mul.in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mul");
    tick();
    rst = 1'b0;
`endif

    run("post_rst_add", 2'b10, 3'b000, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
